// File: rtl/v_en_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v_en_serializer_pkg
// Description : Shared constants for the enable-vector serializer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package v_en_serializer_pkg;

   // Default index width; slot count is always derived as 1 << BIN_WIDTH.
   localparam int C_DEFAULT_BIN_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/cmn_onehot2bin.sv
`default_nettype none
// ============================================================================
// Module      : cmn_onehot2bin
// Description : One-hot to binary index encoder (inverse of cmn_bin2onehot).
//               An all-zero input yields index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cmn_onehot2bin
   import v_en_serializer_pkg::*;
#(
   parameter  int BIN_WIDTH = C_DEFAULT_BIN_WIDTH,
   localparam int OH_WIDTH  = 1 << BIN_WIDTH
) (
   input  logic [OH_WIDTH-1:0]  onehot,
   output logic [BIN_WIDTH-1:0] bin
);

   // OR together the indices of all set bits; exact for a one-hot input.
   always_comb begin
      bin = '0;
      for (int i = 0; i < OH_WIDTH; i++) begin
         if (onehot[i]) begin
            bin = bin | BIN_WIDTH'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/v_en_serializer.sv
`default_nettype none
// ============================================================================
// Module      : v_en_serializer
// Description : Accumulates per-slot enable pulses into a pending bitmap and
//               streams them out one binary index at a time over a
//               valid/ready handshake, round-robin fair.
// Revision    : 1.0 - initial release
// ============================================================================
module v_en_serializer
   import v_en_serializer_pkg::*;
#(
   parameter  int BIN_WIDTH = C_DEFAULT_BIN_WIDTH,
   localparam int OH_WIDTH  = 1 << BIN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OH_WIDTH-1:0]  v_in_en,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [BIN_WIDTH-1:0] out_index,
   output logic [OH_WIDTH-1:0]  pend_vec,
   output logic                 busy
);

   // Output register occupancy is the only control state.
   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [OH_WIDTH-1:0]  r_pend;
   logic [OH_WIDTH-1:0]  w_pend_nxt;
   logic [BIN_WIDTH-1:0] r_index;
   logic [BIN_WIDTH-1:0] w_index_nxt;
   logic [BIN_WIDTH-1:0] r_ptr;
   logic [BIN_WIDTH-1:0] w_ptr_nxt;

   logic                 w_load;
   logic                 w_sel_vld;
   logic [OH_WIDTH-1:0]  w_rot;
   logic [OH_WIDTH-1:0]  w_first;
   logic [OH_WIDTH-1:0]  w_pick;
   logic [OH_WIDTH-1:0]  w_clr;
   logic [BIN_WIDTH-1:0] w_sel;

   // Rotate pending right by ptr so the search always starts at bit 0;
   // the index sum wraps naturally at BIN_WIDTH bits.
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < OH_WIDTH; i++) begin
         w_rot[i] = r_pend[BIN_WIDTH'(i) + r_ptr];
      end
   end

   // Isolate the lowest set bit of the rotated view (first from ptr upward).
   assign w_first   = w_rot & (~w_rot + OH_WIDTH'(1));
   assign w_sel_vld = |r_pend;

   // Rotate the single winning bit back into slot coordinates.
   always_comb begin
      w_pick = '0;
      for (int i = 0; i < OH_WIDTH; i++) begin
         w_pick[BIN_WIDTH'(i) + r_ptr] = w_first[i];
      end
   end

   cmn_onehot2bin #(
      .BIN_WIDTH (BIN_WIDTH)
   ) u_onehot2bin (
      .onehot (w_pick),
      .bin    (w_sel)
   );

   // Next-state: load the output register when it is empty or being drained,
   // and let fresh pulses win over the clear of the slot being loaded.
   always_comb begin
      w_load      = (r_state == S_EMPTY) || out_rdy;
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_ptr_nxt   = r_ptr;
      w_clr       = '0;
      if (w_load) begin
         if (w_sel_vld) begin
            w_state_nxt = S_HOLD;
            w_index_nxt = w_sel;
            w_ptr_nxt   = w_sel + BIN_WIDTH'(1);
            w_clr       = w_pick;
         end else begin
            w_state_nxt = S_EMPTY;
         end
      end
      w_pend_nxt = (r_pend & ~w_clr) | v_in_en;
   end

   // State register; reset drops every pending event immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_pend  <= '0;
         r_index <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_index <= w_index_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign out_vld   = (r_state == S_HOLD);
   assign out_index = r_index;
   assign pend_vec  = r_pend;
   assign busy      = out_vld | (|r_pend);

endmodule
`default_nettype wire
